// File: rtl/dct_frame_loader.sv
// -----------------------------------------------------------------------------
// dct_frame_loader
//
// Front end of the 64-point DCT even/odd engines. Collects 24-bit samples from
// a serial valid/ready stream into frames of eight and presents each complete
// frame as parallel words a0..a7. It also drives the shared 4-bit cnt_clk
// sequence that the downstream stages use to time their pipeline steps.
//
// Sample storage is double-buffered. A fill buffer collects the next frame
// while a0..a7 hold the frame that is currently running.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_data    in   24  sample (two's complement, stored verbatim)
//   in_valid   in   1   in_data carries a sample
//   in_ready   out  1   loader will take a sample this cycle
//   a0..a7     out  24  held frame; a0 is the first sample of the frame
//   cnt_clk    out  4   run sequence count (CNT_IDLE when no frame runs)
//   busy       out  1   cnt_clk != CNT_IDLE
//   frame_done out  1   one-cycle pulse after the last cycle of a run
//   frame_cnt  out  16  loads since reset, wrapping
//                       (present only with DCT_LOADER_FRAME_CNT_EN defined)
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready does not depend on in_valid. Once the producer raises in_valid, it
// holds in_data and in_valid until that transfer edge.
//
// The state machine is encoded in cnt_clk. While cnt_clk == CNT_IDLE the
// block is IDLE. Values 0..CNT_LAST mean RUN. cnt_clk is the state
// observation point.
//
// Optional feature macro: DCT_LOADER_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module dct_frame_loader #(
  parameter logic [3:0] CNT_LAST = 4'd13,
  parameter logic [3:0] CNT_IDLE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] a0,
  output logic [23:0] a1,
  output logic [23:0] a2,
  output logic [23:0] a3,
  output logic [23:0] a4,
  output logic [23:0] a5,
  output logic [23:0] a6,
  output logic [23:0] a7,
  output logic [3:0]  cnt_clk,
  output logic        busy,
  output logic        frame_done
`ifdef DCT_LOADER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  logic [23:0] fill_q [8];
  logic [23:0] fill_d [8];
  logic [23:0] a_q    [8];
  logic [23:0] a_d    [8];
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic        full_q, full_d;
  logic        in_ready_q, in_ready_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
`ifdef DCT_LOADER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

  logic accept;
  logic last_accept;
  logic frame_avail;
  logic at_end;
  logic is_idle;
  logic load;

  always_comb begin
    accept      = in_valid && in_ready_q;
    last_accept = accept && (wr_idx_q == 3'd7);
    // A frame is available when one is already parked in the fill buffer.
    // It is also available when this edge supplies the 8th sample.
    frame_avail = full_q || last_accept;
    at_end      = (cnt_q == CNT_LAST);
    is_idle     = (cnt_q == CNT_IDLE);
    load        = frame_avail && (is_idle || at_end);

    fill_d = fill_q;
    if (accept) begin
      fill_d[wr_idx_q] = in_data;
    end
    wr_idx_d = accept ? (wr_idx_q + 3'd1) : wr_idx_q;

    // A completed frame that cannot load yet parks here and stalls the input.
    full_d     = frame_avail && !load;
    in_ready_d = !full_d;

    // Load from fill_d so a coinciding 8th sample lands directly in a7.
    a_d = a_q;
    if (load) begin
      a_d = fill_d;
    end

    if (load) begin
      cnt_d = 4'd0;
    end else if (at_end) begin
      cnt_d = CNT_IDLE;
    end else if (!is_idle) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    busy_d       = (cnt_d != CNT_IDLE);
    frame_done_d = at_end;

`ifdef DCT_LOADER_FRAME_CNT_EN
    frame_cnt_d = load ? (frame_cnt_q + 16'd1) : frame_cnt_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        fill_q[i] <= '0;
        a_q[i]    <= '0;
      end
      wr_idx_q     <= '0;
      full_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= CNT_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DCT_LOADER_FRAME_CNT_EN
      frame_cnt_q  <= '0;
`endif
    end else begin
      fill_q       <= fill_d;
      a_q          <= a_d;
      wr_idx_q     <= wr_idx_d;
      full_q       <= full_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef DCT_LOADER_FRAME_CNT_EN
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign a0         = a_q[0];
  assign a1         = a_q[1];
  assign a2         = a_q[2];
  assign a3         = a_q[3];
  assign a4         = a_q[4];
  assign a5         = a_q[5];
  assign a6         = a_q[6];
  assign a7         = a_q[7];
  assign cnt_clk    = cnt_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
`ifdef DCT_LOADER_FRAME_CNT_EN
  assign frame_cnt  = frame_cnt_q;
`endif

endmodule
